// File: rtl/demux_router_pkg.sv
// Shared definitions for the mux/demux family.
//   DEF_WIDTH / DEF_DEPTH / DEF_SELECT_LINE_DEPTH : default geometry
//   DROP_CNT_W                                    : width of the drop counter
//   slot_state_t                                  : per-channel holding register state
package mux_pkg;
  localparam int unsigned DEF_WIDTH             = 32;
  localparam int unsigned DEF_DEPTH             = 16;
  localparam int unsigned DEF_SELECT_LINE_DEPTH = 4;
  localparam int unsigned DROP_CNT_W            = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;
endpackage

// File: rtl/demux_router_if.sv
// Handshake bundle for demux_router.
//   in_valid/in_ready/in_data/s : single producer-side beat with destination index
//   out_valid/out_ready/out     : per-channel consumer-side handshake and payload
// slave modport is the router's view; master modport is the producer/consumer view.
interface demux_router_if #(
  parameter int unsigned WIDTH             = 32,
  parameter int unsigned DEPTH             = 16,
  parameter int unsigned SELECT_LINE_DEPTH = 4
);
  logic                         in_valid;
  logic                         in_ready;
  logic [WIDTH-1:0]             in_data;
  logic [SELECT_LINE_DEPTH-1:0] s;
  logic [DEPTH-1:0]             out_valid;
  logic [DEPTH-1:0]             out_ready;
  logic [WIDTH-1:0]             out [DEPTH];

  modport slave (
    input  in_valid, in_data, s, out_ready,
    output in_ready, out_valid, out
  );

  modport master (
    output in_valid, in_data, s, out_ready,
    input  in_ready, out_valid, out
  );
endinterface

// File: rtl/demux_router_slot.sv
// One-entry holding register for a single output channel.
//   clk, rst : clock and synchronous active-high reset
//   load     : accept din this cycle (router has already checked space)
//   din      : payload to capture
//   ready    : consumer accepts the held beat
//   valid    : a beat is held (registered)
//   data     : held payload; retains last value after draining
module demux_slot
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  slot_state_t state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      valid   <= 1'b0;
      data    <= '0;
    end else if (load) begin
      // Load wins over drain: a simultaneous drain+load keeps the slot FULL.
      state_q <= FULL;
      valid   <= 1'b1;
      data    <= din;
    end else if (state_q == FULL && ready) begin
      state_q <= EMPTY;
      valid   <= 1'b0;
    end
  end
endmodule

// File: rtl/demux_router.sv
// Registered 1-to-DEPTH demultiplexer with valid/ready handshaking.
//   clk, rst : clock and synchronous active-high reset
//   bus      : demux_router_if slave view (input beat + per-channel outputs)
//   drop_cnt : saturating count of beats discarded for out-of-range s
module demux_router
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH             = DEF_WIDTH,
  parameter int unsigned DEPTH             = DEF_DEPTH,
  parameter int unsigned SELECT_LINE_DEPTH = DEF_SELECT_LINE_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  demux_router_if.slave         bus,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  logic             in_range;
  logic             sel_valid;
  logic             sel_ready;
  logic             fire;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] slot_valid;
  logic [WIDTH-1:0] slot_data [DEPTH];

  assign in_range = 32'(bus.s) < DEPTH;

  // Explicit decode loop so an out-of-range s never indexes past DEPTH.
  always_comb begin
    sel_valid = 1'b0;
    sel_ready = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (32'(bus.s) == k) begin
        sel_valid = slot_valid[k];
        sel_ready = bus.out_ready[k];
      end
    end
  end

  // Out-of-range beats are always accepted so they can be dropped.
  assign bus.in_ready = !rst && (!in_range || !sel_valid || sel_ready);
  assign fire         = bus.in_valid && bus.in_ready;

  always_comb begin
    load = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (fire && 32'(bus.s) == k) load[k] = 1'b1;
    end
  end

  for (genvar k = 0; k < int'(DEPTH); k++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .din   (bus.in_data),
      .ready (bus.out_ready[k]),
      .valid (slot_valid[k]),
      .data  (slot_data[k])
    );
  end

  assign bus.out_valid = slot_valid;
  assign bus.out       = slot_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (fire && !in_range && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule
